// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register with a valid/ready handshake and a skid entry.
// Define PIPE_PERF_EN to build the saturating stall/bubble/flush counters.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StFull);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Zero is the pipeline bubble; any word offered this cycle is dropped.
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (out_valid && !out_ready && (stall_q != CntMax)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (!out_valid && (bubble_q != CntMax)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
    if (flush && (flush_q != CntMax)) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic
// compared against a queue-based model of the stage.
module tb_pipe_skid_reg;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 2;
  localparam int          CntMax = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  // Model: held words in order, plus the word left in the head register when empty.
  logic [W-1:0] q[$];
  logic [W-1:0] idle_word;
  int           m_stall, m_bubble, m_flush;

  pipe_skid_reg #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    idle_word = '0;
    m_stall   = 0;
    m_bubble  = 0;
    m_flush   = 0;
  endtask

  task automatic check_all();
    logic [W-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : idle_word;
    check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check_eq("occupancy", 64'(occupancy), 64'(q.size()));
    check_eq("out_data", 64'(out_data), 64'(exp_data));
`ifdef PIPE_PERF_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
    check_eq("stall_cnt", 64'(stall_cnt), 64'd0);
    check_eq("bubble_cnt", 64'(bubble_cnt), 64'd0);
    check_eq("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
  endtask

  // Effect of one clock edge given the inputs present before it.
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit           ov, ir;
    logic [W-1:0] popped;
    ov = q.size() > 0;
    ir = q.size() < 2;
    if (ov && !r && m_stall < CntMax) m_stall++;
    if (!ov && m_bubble < CntMax) m_bubble++;
    if (f && m_flush < CntMax) m_flush++;
    if (f) begin
      q.delete();
      idle_word = '0;
    end else begin
      if (ov && r) begin
        popped = q.pop_front();
        if (q.size() == 0) idle_word = popped;
      end
      if (v && ir) q.push_back(d);
    end
  endtask

  // Called at a falling edge: drive, advance one cycle, check at the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    model_edge(v, d, r, f);
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    logic         v, r, f, pend;
    logic [W-1:0] d;
    nRST      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge CLK);
    nRST = 1'b1;
    check_all();

    // Back-to-back stream with the consumer always ready.
    step(1'b1, 16'h1, 1'b1, 1'b0);
    step(1'b1, 16'h2, 1'b1, 1'b0);
    step(1'b1, 16'h3, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Skid fill then drain.
    step(1'b1, 16'hA, 1'b0, 1'b0);
    step(1'b1, 16'hB, 1'b0, 1'b0);
    step(1'b1, 16'hC, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush while full with a word offered, then flush in ONE while delivering.
    step(1'b1, 16'hA, 1'b0, 1'b0);
    step(1'b1, 16'hB, 1'b0, 1'b0);
    step(1'b1, 16'hC, 1'b0, 1'b1);
    step(1'b1, 16'h5, 1'b0, 1'b0);
    step(1'b1, 16'h6, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    // Long stall saturates the stall counter.
    step(1'b1, 16'h9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall, between clock edges.
    step(1'b1, 16'h7, 1'b0, 1'b0);
    step(1'b1, 16'h8, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check_all();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    nRST      = 1'b1;
    model_edge(1'b0, '0, 1'b0, 1'b0);
    @(negedge CLK);
    check_all();

    // Random traffic; an unaccepted offer is held until taken.
    pend = 1'b0;
    v    = 1'b0;
    d    = '0;
    for (int i = 0; i < 500; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end
      r    = ($urandom_range(0, 3) != 0);
      f    = ($urandom_range(0, 19) == 0);
      pend = v && (q.size() >= 2) && !f;
      step(v, d, r, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
